wb_uart_tx: RTL and testbench

//  Wishbone-attached UART transmitter. CPU writes bytes into a small FIFO.

---
 rtl/wb_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_wb_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// Wishbone-attached 8N1 UART transmitter with a small byte FIFO and a
// drain-complete level interrupt.
module wb_uart_tx #(
    parameter int TICKS_PER_BAUD = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int DATA_INVERT    = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       int_uart_tx,
    output logic       uart_tx
);

    localparam int   PW  = $clog2(FIFO_DEPTH);
    localparam int   CW  = (TICKS_PER_BAUD > 2) ? $clog2(TICKS_PER_BAUD) : 1;
    localparam logic Inv = DATA_INVERT[0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   baudCnt_q, baudCnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ack_q, ack_d;
    logic [7:0]      dat_q, dat_d;
    logic            int_q, int_d;
    logic [PW:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic req, full, empty, push, pop, stopDone, baudEnd;
    logic [7:0] status;

    assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign full    = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    assign empty   = (wrPtr_q == rdPtr_q);
    assign push    = req & wb_we_i & ~full;
    assign status  = {5'b0, empty, full, state_q != IDLE};
    assign baudEnd = (baudCnt_q == CW'(TICKS_PER_BAUD - 1));

    // A write stalls (no ack) while the FIFO is full; full is taken from the
    // registered pointers, so a pop on the same edge does not admit it.
    always_comb begin
        ack_d   = req & (~wb_we_i | ~full);
        dat_d   = dat_q;
        if (req && !wb_we_i) begin
            dat_d = status;
        end
        wrPtr_d = wrPtr_q + {{PW{1'b0}}, push};
    end

    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q + CW'(1);
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        stopDone  = 1'b0;
        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rdPtr_q[PW-1:0]];
                    state_d = START;
                end
            end
            START: begin
                if (baudEnd) begin
                    baudCnt_d = '0;
                    bitIdx_d  = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baudEnd) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baudEnd) begin
                    baudCnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rdPtr_q[PW-1:0]];
                        state_d = START;
                    end else begin
                        stopDone = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rdPtr_d = rdPtr_q + {{PW{1'b0}}, pop};
    end

    // The line is derived from the next state so it changes on the same edge
    // as the FSM and comes straight out of a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bitIdx_d] ^ Inv;
            default: tx_d = 1'b1;
        endcase
        int_d = int_q;
        if (req) begin
            int_d = 1'b0;
        end else if (stopDone) begin
            int_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            ack_q     <= 1'b0;
            dat_q     <= 8'h04;
            int_q     <= 1'b0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            int_q     <= int_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wrPtr_q[PW-1:0]] <= wb_dat_i;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign int_uart_tx = int_q;
    assign uart_tx     = tx_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: one instance with plain data bits and one
// with inverted data bits, checked cycle by cycle on the serial line.
module tb_wb_uart_tx;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] cyc, stb;
    logic       we;
    logic [7:0] datI;
    wire  [7:0] datO0, datO1;
    wire  [1:0] ack, intr, tx;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    wb_uart_tx #(.TICKS_PER_BAUD(8), .FIFO_DEPTH(4), .DATA_INVERT(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rstN), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_we_i(we), .wb_dat_i(datI), .wb_dat_o(datO0), .wb_ack_o(ack[0]),
        .int_uart_tx(intr[0]), .uart_tx(tx[0])
    );

    wb_uart_tx #(.TICKS_PER_BAUD(8), .FIFO_DEPTH(4), .DATA_INVERT(1)) dutInv (
        .wb_clk_i(clk), .wb_rst_ni(rstN), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_we_i(we), .wb_dat_i(datI), .wb_dat_o(datO1), .wb_ack_o(ack[1]),
        .int_uart_tx(intr[1]), .uart_tx(tx[1])
    );

    // Single comparison point: every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Bus write; waits counts negedges from driving the request to seeing ack.
    task automatic busWrite(input int sel, input logic [7:0] b, output int waits);
        @(negedge clk);
        cyc[sel] = 1'b1; stb[sel] = 1'b1; we = 1'b1; datI = b;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (ack[sel] !== 1'b1 && waits < 500);
        checkOutput("writeAck", 32'(ack[sel]), 32'd1);
        cyc[sel] = 1'b0; stb[sel] = 1'b0; we = 1'b0;
    endtask

    task automatic busRead(input int sel, output logic [7:0] st);
        int n;
        @(negedge clk);
        cyc[sel] = 1'b1; stb[sel] = 1'b1; we = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[sel] !== 1'b1 && n < 50);
        checkOutput("readAck", 32'(ack[sel]), 32'd1);
        checkOutput("readLatency", n, 32'd1);
        st = (sel == 1) ? datO1 : datO0;
        cyc[sel] = 1'b0; stb[sel] = 1'b0;
    endtask

    // Checks a whole 80-clock frame. With first set it first polls for the start
    // bit; otherwise the start bit must begin on the very next clock.
    task automatic expectFrame(input int sel, input logic [7:0] b, input logic inv,
                               input bit first, input string tag, output int polls);
        logic expBit;
        int   k;
        polls = 0;
        if (first) begin
            do begin
                @(negedge clk);
                polls++;
            end while (tx[sel] !== 1'b0 && polls < 300);
        end else begin
            @(negedge clk);
        end
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            k = c / 8;
            if (k == 0)      expBit = 1'b0;
            else if (k == 9) expBit = 1'b1;
            else             expBit = b[k-1] ^ inv;
            checkOutput(tag, 32'(tx[sel]), 32'(expBit));
        end
        checkOutput({tag, "_intBeforeEnd"}, 32'(intr[sel]), 32'd0);
    endtask

    task automatic applyStimulus();
        int          w, p;
        logic [7:0]  st;
        logic [7:0]  bytes [6];

        // Power-on reset
        rstN = 1'b0; cyc = 2'b00; stb = 2'b00; we = 1'b0; datI = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rstTx0", 32'(tx[0]), 32'd1);
        checkOutput("rstTx1", 32'(tx[1]), 32'd1);
        checkOutput("rstDat", 32'(datO0), 32'h04);
        checkOutput("rstAck", 32'(ack), 32'd0);
        checkOutput("rstInt", 32'(intr), 32'd0);
        rstN = 1'b1;

        $display("[TB] single frame 0xA5, plain data");
        busWrite(0, 8'hA5, w);
        checkOutput("t2Waits", w, 32'd1);
        expectFrame(0, 8'hA5, 1'b0, 1'b1, "t2Frame", p);
        checkOutput("t2StartLatency", p, 32'd1);
        @(negedge clk);
        checkOutput("t2IntRise", 32'(intr[0]), 32'd1);
        checkOutput("t2IdleLine", 32'(tx[0]), 32'd1);
        busRead(0, st);
        checkOutput("t2IdleStatus", 32'(st), 32'h04);
        checkOutput("t2IntCleared", 32'(intr[0]), 32'd0);

        $display("[TB] inverted data, byte 0x00");
        busWrite(1, 8'h00, w);
        expectFrame(1, 8'h00, 1'b1, 1'b1, "t3Frame", p);
        @(negedge clk);
        checkOutput("t3Int", 32'(intr[1]), 32'd1);

        $display("[TB] five writes from idle, back-to-back frames");
        bytes = '{8'h3C, 8'h81, 8'hFF, 8'h12, 8'hE7, 8'h00};
        fork
            begin
                int wl;
                for (int i = 0; i < 5; i++) begin
                    busWrite(0, bytes[i], wl);
                    checkOutput("t4Waits", wl, 32'd1);
                end
            end
            begin
                int pl;
                expectFrame(0, bytes[0], 1'b0, 1'b1, "t4Frame0", pl);
                for (int i = 1; i < 5; i++) expectFrame(0, bytes[i], 1'b0, 1'b0, "t4FrameN", pl);
            end
        join
        @(negedge clk);
        checkOutput("t4IntRise", 32'(intr[0]), 32'd1);

        $display("[TB] sixth write stalls on a full FIFO");
        bytes = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h6B};
        fork
            begin
                int wl;
                for (int i = 0; i < 5; i++) begin
                    busWrite(0, bytes[i], wl);
                    checkOutput("t5Waits", wl, 32'd1);
                end
                busWrite(0, bytes[5], wl);
                checkOutput("t5StallWaits", wl, 32'd73);
            end
            begin
                int pl;
                expectFrame(0, bytes[0], 1'b0, 1'b1, "t5Frame0", pl);
                for (int i = 1; i < 6; i++) expectFrame(0, bytes[i], 1'b0, 1'b0, "t5FrameN", pl);
            end
        join
        @(negedge clk);
        checkOutput("t5IntRise", 32'(intr[0]), 32'd1);

        $display("[TB] status reads during and after frames");
        busWrite(0, 8'h55, w);
        busWrite(0, 8'hAA, w);
        busRead(0, st);
        checkOutput("t6StatusBusy", 32'(st), 32'h01);
        repeat (100) @(negedge clk);
        checkOutput("t6IntMidStream", 32'(intr[0]), 32'd0);
        busRead(0, st);
        checkOutput("t6StatusLast", 32'(st), 32'h05);
        repeat (100) @(negedge clk);
        checkOutput("t6IntSet", 32'(intr[0]), 32'd1);
        busRead(0, st);
        checkOutput("t6StatusIdle", 32'(st), 32'h04);
        checkOutput("t6IntCleared", 32'(intr[0]), 32'd0);

        $display("[TB] reset mid-frame");
        busWrite(0, 8'h00, w);
        repeat (20) @(negedge clk);
        checkOutput("t1LineLowBefore", 32'(tx[0]), 32'd0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t1TxAsync", 32'(tx[0]), 32'd1);
        checkOutput("t1IntAsync", 32'(intr[0]), 32'd0);
        checkOutput("t1DatAsync", 32'(datO0), 32'h04);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        busRead(0, st);
        checkOutput("t1Status", 32'(st), 32'h04);
        repeat (20) @(negedge clk);
        checkOutput("t1StaysIdle", 32'(tx[0]), 32'd1);
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
